// File: rtl/fifo_real.sv
// Synchronous FIFO for fixed-point real samples; each sample is re-aligned from the in format to the out format on entry.
// Optional sticky overflow/underflow status ports are enabled by defining FIFO_REAL_STATUS_EN.
module fifo_real #(
    parameter int  DEPTH     = 8,
    parameter real init      = 0.0,
    parameter int  in_width  = 16,
    parameter int  in_frac   = 8,
    parameter int  out_width = 16,
    parameter int  out_frac  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [in_width-1:0]      in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [out_width-1:0]     out,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef FIFO_REAL_STATUS_EN
    output logic                     overflow,
    output logic                     underflow,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SH   = out_frac - in_frac;
    localparam int LSH  = (SH > 0) ? SH : 0;
    localparam int RSH  = (SH < 0) ? -SH : 0;
    localparam int WIDE = (in_width + LSH > out_width) ? (in_width + LSH) : out_width;
    localparam logic [out_width-1:0] INIT_FX = out_width'($rtoi(init * (2.0 ** out_frac)));

    logic [out_width-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic signed [WIDE-1:0] ext;
    logic [out_width-1:0] aligned;
    logic                 push;
    logic                 pop;

    // Sign-extend, shift to the out binary point (arithmetic right shift truncates toward -inf), then wrap to out_width.
    assign ext     = WIDE'($signed(in));
    assign aligned = out_width'((ext <<< LSH) >>> RSH);

    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign out       = out_valid ? mem[rd_ptr] : INIT_FX;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_REAL_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (in_valid && !in_ready)   overflow  <= 1'b1;
            if (out_ready && !out_valid) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_real.sv
// Directed bench for fifo_real: DEPTH 4, in Q20.12, out Q16.8, init 1.5 (0x180 in out format).
`timescale 1ns/1ps
module tb_fifo_real;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
`ifdef FIFO_REAL_STATUS_EN
    logic        overflow;
    logic        underflow;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    fifo_real #(
        .DEPTH(4), .init(1.5),
        .in_width(20), .in_frac(12),
        .out_width(16), .out_frac(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
`ifdef FIFO_REAL_STATUS_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [19:0] v);
        in = v; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        out_ready = 1'b1; in_valid = 1'b0;
        check(tag, {16'b0, out}, exp);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in = '0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_init", {16'b0, out}, 32'h0180);
`ifdef FIFO_REAL_STATUS_EN
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_underflow", {31'b0, underflow}, 32'd0);
`endif

        // 1.25, -0.5, 3.0 in Q20.12 -> 0x140, 0xFF80, 0x300 in Q16.8
        push(20'h01400); push(20'hFF800); push(20'h03000);
        check("three_count", {29'b0, count}, 32'd3);
        pop_check("order0", 32'h0140);
        pop_check("order1", 32'hFF80);
        pop_check("order2", 32'h0300);
        check("drained_valid", {31'b0, out_valid}, 32'd0);
        check("drained_out", {16'b0, out}, 32'h0180);
        check("drained_count", {29'b0, count}, 32'd0);

        // Fill DEPTH=4 with 1.0..4.0, 5.0 must be refused.
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in = 20'(k * 4096);
            step();
            if (k == 4) begin
                check("full_in_ready", {31'b0, in_ready}, 32'd0);
                check("full_count", {29'b0, count}, 32'd4);
            end
        end
        check("full_hold_count", {29'b0, count}, 32'd4);
        // Pop while full with in_valid high: no push may fire.
        in = 20'(6 * 4096); in_valid = 1'b1; out_ready = 1'b1;
        check("full_pop_head", {16'b0, out}, 32'h0100);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("after_full_pop_count", {29'b0, count}, 32'd3);
        check("after_full_pop_ready", {31'b0, in_ready}, 32'd1);
        pop_check("full_rest2", 32'h0200);
        pop_check("full_rest3", 32'h0300);
        pop_check("full_rest4", 32'h0400);
        check("full_empty_again", {29'b0, count}, 32'd0);

        // Steady state at count 2 with simultaneous push/pop, pointers wrap several times.
        push(20'(10 * 4096)); exp_q.push_back(32'(10 * 256));
        push(20'(11 * 4096)); exp_q.push_back(32'(11 * 256));
        for (int i = 0; i < 20; i++) begin
            in = 20'((12 + i) * 4096); in_valid = 1'b1; out_ready = 1'b1;
            check("stream_out", {16'b0, out}, exp_q.pop_front());
            exp_q.push_back(32'((12 + i) * 256));
            step();
            check("stream_count", {29'b0, count}, 32'd2);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        pop_check("stream_tail0", exp_q.pop_front());
        pop_check("stream_tail1", exp_q.pop_front());

        // 0.123456 ~ 505/4096 -> 505>>>4 = 31; -505>>>4 = -32 (floor).
        push(20'd505); push(20'hFFE07); push(20'h01000); push(20'h02000);
        pop_check("align_pos", 32'h001F);
        check("align_neg", {16'b0, out}, 32'hFFE0);
        check("pre_rst_count", {29'b0, count}, 32'd3);
        // Reset with push and pop presented together: all ignored.
        rst = 1'b1; in = 20'h05000; in_valid = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("midrst_count", {29'b0, count}, 32'd0);
        check("midrst_out", {16'b0, out}, 32'h0180);
        check("midrst_valid", {31'b0, out_valid}, 32'd0);

`ifdef FIFO_REAL_STATUS_EN
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("underflow_set", {31'b0, underflow}, 32'd1);
        check("overflow_clear", {31'b0, overflow}, 32'd0);
        for (int k = 0; k < 5; k++) push(20'h01000);
        check("overflow_set", {31'b0, overflow}, 32'd1);
        step(); step();
        check("overflow_sticky", {31'b0, overflow}, 32'd1);
        check("underflow_sticky", {31'b0, underflow}, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("overflow_rst", {31'b0, overflow}, 32'd0);
        check("underflow_rst", {31'b0, underflow}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
